imem_fetch_arbiter: RTL and testbench

//  Shares the single synchronous instruction ROM port (1-cycle registered read) between the

---
 rtl/imem_fetch_arbiter.sv | 160 ++++++++++++++++
 tb/tb_imem_fetch_arbiter.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/imem_fetch_arbiter.sv
// Two-core instruction fetch arbiter sharing one 1-cycle registered ROM port.
// Bad PCs (misaligned or out of range) are answered locally with an error and a NOP.
module imem_fetch_arbiter #(
  parameter int unsigned IMEM_BYTES = 4096,
  parameter bit          FIXED_PRIO = 1'b0,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        c0_req,
  input  logic [31:0] c0_pc,
  input  logic        c0_flush,
  output logic        c0_gnt,
  output logic        c0_rvalid,
  output logic [31:0] c0_instr,
  output logic        c0_err,
  input  logic        c1_req,
  input  logic [31:0] c1_pc,
  input  logic        c1_flush,
  output logic        c1_gnt,
  output logic        c1_rvalid,
  output logic [31:0] c1_instr,
  output logic        c1_err,
  output logic        mem_en,
  output logic [31:0] mem_pc,
  input  logic [31:0] mem_instr
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_C0   = 2'd1,
    OWN_C1   = 2'd2
  } owner_e;

  localparam logic [31:0] IMEM_LIMIT = 32'(IMEM_BYTES);

  function automatic logic pc_is_bad(input logic [31:0] pc);
    return (pc[1:0] != 2'b00) || (pc >= IMEM_LIMIT);
  endfunction

  owner_e      owner_q, owner_d;
  logic        err_q, err_d;
  logic        prio_q, prio_d;
  logic        c0_elig_s, c1_elig_s;
  logic        win0_s, win1_s;
  logic [31:0] win_pc_s;
  logic        win_bad_s;

  // Eligibility is held off while reset is asserted so no grant leaks out during reset.
  always_comb begin
    c0_elig_s = c0_req & ~c0_flush & rst_n;
    c1_elig_s = c1_req & ~c1_flush & rst_n;
  end

  // Arbitration, ROM drive and next-state computation.
  always_comb begin
    win0_s    = c0_elig_s & (~c1_elig_s | FIXED_PRIO | ~prio_q);
    win1_s    = c1_elig_s & ~win0_s;
    win_pc_s  = win1_s ? c1_pc : c0_pc;
    win_bad_s = pc_is_bad(win_pc_s);

    c0_gnt = win0_s;
    c1_gnt = win1_s;

    if ((win0_s | win1_s) && !win_bad_s) begin
      mem_en = 1'b1;
      mem_pc = win_pc_s;
    end else begin
      mem_en = 1'b0;
      mem_pc = 32'h0000_0000;
    end

    owner_d = OWN_NONE;
    err_d   = 1'b0;
    prio_d  = prio_q;
    if (win0_s) begin
      owner_d = OWN_C0;
      err_d   = win_bad_s;
      prio_d  = 1'b1;
    end else if (win1_s) begin
      owner_d = OWN_C1;
      err_d   = win_bad_s;
      prio_d  = 1'b0;
    end else begin
      owner_d = OWN_NONE;
      err_d   = 1'b0;
    end
  end

  // Owner / error / priority state; prio_q = 0 means core 0 is favoured on a tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q <= OWN_NONE;
      err_q   <= 1'b0;
      prio_q  <= 1'b0;
    end else begin
      owner_q <= owner_d;
      err_q   <= err_d;
      prio_q  <= prio_d;
    end
  end

  // Response routing: a flush in the response cycle discards the word.
  always_comb begin
    c0_rvalid = 1'b0;
    c0_err    = 1'b0;
    c0_instr  = 32'h0000_0000;
    c1_rvalid = 1'b0;
    c1_err    = 1'b0;
    c1_instr  = 32'h0000_0000;
    case (owner_q)
      OWN_C0: begin
        c0_rvalid = ~c0_flush;
        c0_err    = err_q & ~c0_flush;
        c0_instr  = c0_flush ? 32'h0000_0000 : (err_q ? NOP_INSTR : mem_instr);
      end
      OWN_C1: begin
        c1_rvalid = ~c1_flush;
        c1_err    = err_q & ~c1_flush;
        c1_instr  = c1_flush ? 32'h0000_0000 : (err_q ? NOP_INSTR : mem_instr);
      end
      OWN_NONE: begin
        c0_rvalid = 1'b0;
        c1_rvalid = 1'b0;
      end
      default: begin
        c0_rvalid = 1'b0;
        c1_rvalid = 1'b0;
      end
    endcase
  end

  imem_fetch_arbiter_chk u_chk (
    .clk       (clk),
    .rst_n     (rst_n),
    .c0_gnt    (c0_gnt),
    .c1_gnt    (c1_gnt),
    .mem_en    (mem_en),
    .c0_rvalid (c0_rvalid),
    .c1_rvalid (c1_rvalid)
  );

endmodule

// Structural invariants of the arbiter, kept apart from the datapath.
module imem_fetch_arbiter_chk (
  input logic clk,
  input logic rst_n,
  input logic c0_gnt,
  input logic c1_gnt,
  input logic mem_en,
  input logic c0_rvalid,
  input logic c1_rvalid
);

  a_one_gnt: assert property (@(posedge clk) disable iff (!rst_n) !(c0_gnt && c1_gnt));
  a_en_gnt:  assert property (@(posedge clk) disable iff (!rst_n) mem_en |-> (c0_gnt ^ c1_gnt));
  a_one_rsp: assert property (@(posedge clk) disable iff (!rst_n) !(c0_rvalid && c1_rvalid));

endmodule

// File: tb/tb_imem_fetch_arbiter.sv
// Directed bench for imem_fetch_arbiter; ROM word at byte address a is 32'hC0DE_0000 + a/4.
module tb_imem_fetch_arbiter;

  logic        clk;
  logic        rst_n;
  logic        c0_req, c0_flush, c0_gnt, c0_rvalid, c0_err;
  logic [31:0] c0_pc, c0_instr;
  logic        c1_req, c1_flush, c1_gnt, c1_rvalid, c1_err;
  logic [31:0] c1_pc, c1_instr;
  logic        mem_en;
  logic [31:0] mem_pc, mem_instr;

  int n_assert = 0;
  int n_fail   = 0;

  imem_fetch_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .c0_req    (c0_req),
    .c0_pc     (c0_pc),
    .c0_flush  (c0_flush),
    .c0_gnt    (c0_gnt),
    .c0_rvalid (c0_rvalid),
    .c0_instr  (c0_instr),
    .c0_err    (c0_err),
    .c1_req    (c1_req),
    .c1_pc     (c1_pc),
    .c1_flush  (c1_flush),
    .c1_gnt    (c1_gnt),
    .c1_rvalid (c1_rvalid),
    .c1_instr  (c1_instr),
    .c1_err    (c1_err),
    .mem_en    (mem_en),
    .mem_pc    (mem_pc),
    .mem_instr (mem_instr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous ROM model, 1-cycle registered read.
  initial mem_instr = 32'h0000_0000;
  always @(posedge clk) begin
    if (mem_en) mem_instr <= {16'hC0DE, 2'b00, mem_pc[15:2]};
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  initial begin
    rst_n = 1'b0;
    c0_req = 1'b0; c0_pc = 32'h0; c0_flush = 1'b0;
    c1_req = 1'b0; c1_pc = 32'h0; c1_flush = 1'b0;

    // 1: reset with both requesting
    c0_req = 1'b1; c1_req = 1'b1; c0_pc = 32'h0; c1_pc = 32'h20;
    settle();
    chk("rst_c0_gnt", c0_gnt, 32'd0);
    chk("rst_c1_gnt", c1_gnt, 32'd0);
    chk("rst_mem_en", mem_en, 32'd0);
    chk("rst_mem_pc", mem_pc, 32'h0);
    chk("rst_c0_rvalid", c0_rvalid, 32'd0);
    chk("rst_c1_rvalid", c1_rvalid, 32'd0);
    chk("rst_c0_instr", c0_instr, 32'h0);
    tick();
    rst_n = 1'b1;
    settle();
    chk("rel_c0_gnt", c0_gnt, 32'd1);
    chk("rel_c1_gnt", c1_gnt, 32'd0);
    chk("rel_mem_en", mem_en, 32'd1);
    chk("rel_mem_pc", mem_pc, 32'h0);
    tick();
    c0_req = 1'b0;
    settle();
    chk("rel2_c1_gnt", c1_gnt, 32'd1);
    chk("rel2_mem_pc", mem_pc, 32'h20);
    chk("rel2_c0_rvalid", c0_rvalid, 32'd1);
    chk("rel2_c0_instr", c0_instr, 32'hC0DE_0000);
    tick();
    c1_req = 1'b0;
    settle();
    chk("rel3_c1_rvalid", c1_rvalid, 32'd1);
    chk("rel3_c1_instr", c1_instr, 32'hC0DE_0008);
    chk("rel3_c0_rvalid", c0_rvalid, 32'd0);
    tick();

    // 2: core 0 alone, back-to-back fetches
    c0_req = 1'b1; c0_pc = 32'h0;
    settle();
    chk("seq0_gnt", c0_gnt, 32'd1);
    chk("seq0_rvalid", c0_rvalid, 32'd0);
    tick();
    c0_pc = 32'h4;
    settle();
    chk("seq1_gnt", c0_gnt, 32'd1);
    chk("seq1_mem_pc", mem_pc, 32'h4);
    chk("seq1_rvalid", c0_rvalid, 32'd1);
    chk("seq1_instr", c0_instr, 32'hC0DE_0000);
    chk("seq1_err", c0_err, 32'd0);
    tick();
    c0_pc = 32'h8;
    settle();
    chk("seq2_gnt", c0_gnt, 32'd1);
    chk("seq2_instr", c0_instr, 32'hC0DE_0001);
    tick();
    c0_req = 1'b0;
    settle();
    chk("seq3_gnt", c0_gnt, 32'd0);
    chk("seq3_mem_en", mem_en, 32'd0);
    chk("seq3_rvalid", c0_rvalid, 32'd1);
    chk("seq3_instr", c0_instr, 32'hC0DE_0002);
    tick();
    settle();
    chk("seq4_rvalid", c0_rvalid, 32'd0);

    // 4: core 1 bad PCs (misaligned, then out of range)
    c1_req = 1'b1; c1_pc = 32'h6;
    settle();
    chk("mis_gnt", c1_gnt, 32'd1);
    chk("mis_mem_en", mem_en, 32'd0);
    tick();
    c1_pc = 32'd4096;
    settle();
    chk("mis_rvalid", c1_rvalid, 32'd1);
    chk("mis_err", c1_err, 32'd1);
    chk("mis_instr", c1_instr, 32'h0000_0013);
    chk("oor_gnt", c1_gnt, 32'd1);
    chk("oor_mem_en", mem_en, 32'd0);
    tick();
    c1_req = 1'b0;
    settle();
    chk("oor_rvalid", c1_rvalid, 32'd1);
    chk("oor_err", c1_err, 32'd1);
    chk("oor_instr", c1_instr, 32'h0000_0013);
    chk("oor_c0_rvalid", c0_rvalid, 32'd0);
    tick();

    // 3: both cores requesting continuously
    c0_req = 1'b1; c0_pc = 32'h10; c1_req = 1'b1; c1_pc = 32'h20;
    settle();
    chk("rr1_c0_gnt", c0_gnt, 32'd1);
    chk("rr1_c1_gnt", c1_gnt, 32'd0);
    chk("rr1_mem_pc", mem_pc, 32'h10);
    tick();
    settle();
    chk("rr2_c1_gnt", c1_gnt, 32'd1);
    chk("rr2_c0_gnt", c0_gnt, 32'd0);
    chk("rr2_mem_pc", mem_pc, 32'h20);
    chk("rr2_c0_rvalid", c0_rvalid, 32'd1);
    chk("rr2_c0_instr", c0_instr, 32'hC0DE_0004);
    chk("rr2_c1_rvalid", c1_rvalid, 32'd0);
    tick();
    settle();
    chk("rr3_c0_gnt", c0_gnt, 32'd1);
    chk("rr3_c1_rvalid", c1_rvalid, 32'd1);
    chk("rr3_c1_instr", c1_instr, 32'hC0DE_0008);
    chk("rr3_c0_rvalid", c0_rvalid, 32'd0);
    tick();
    settle();
    chk("rr4_c1_gnt", c1_gnt, 32'd1);
    chk("rr4_c0_rvalid", c0_rvalid, 32'd1);
    chk("rr4_c0_instr", c0_instr, 32'hC0DE_0004);
    tick();
    c0_req = 1'b0; c1_req = 1'b0;
    settle();
    chk("rr5_c1_rvalid", c1_rvalid, 32'd1);
    chk("rr5_c1_instr", c1_instr, 32'hC0DE_0008);
    chk("rr5_c0_gnt", c0_gnt, 32'd0);
    chk("rr5_c1_gnt", c1_gnt, 32'd0);
    tick();

    // 5: flush of core 0 response; core 1 unaffected
    c0_req = 1'b1; c0_pc = 32'h8;
    settle();
    chk("fl_c0_gnt", c0_gnt, 32'd1);
    tick();
    c0_flush = 1'b1; c1_req = 1'b1; c1_pc = 32'h20;
    settle();
    chk("fl_c0_rvalid", c0_rvalid, 32'd0);
    chk("fl_c0_gnt", c0_gnt, 32'd0);
    chk("fl_c1_gnt", c1_gnt, 32'd1);
    tick();
    c1_req = 1'b0;
    settle();
    chk("fl_c1_rvalid", c1_rvalid, 32'd1);
    chk("fl_c1_instr", c1_instr, 32'hC0DE_0008);
    chk("fl_c0_gnt2", c0_gnt, 32'd0);
    tick();
    c0_flush = 1'b0; c0_req = 1'b0;
    settle();
    chk("fl_idle_c0_rvalid", c0_rvalid, 32'd0);

    // 6: reset one cycle after a grant
    c0_req = 1'b1; c0_pc = 32'hC;
    settle();
    chk("rm_c0_gnt", c0_gnt, 32'd1);
    tick();
    c0_req = 1'b0; rst_n = 1'b0;
    settle();
    chk("rm_c0_rvalid_rst", c0_rvalid, 32'd0);
    tick();
    rst_n = 1'b1;
    settle();
    chk("rm_c0_rvalid_rel", c0_rvalid, 32'd0);
    chk("rm_c1_rvalid_rel", c1_rvalid, 32'd0);
    tick();
    c0_req = 1'b1; c0_pc = 32'h10; c1_req = 1'b1; c1_pc = 32'h20;
    settle();
    chk("rm_prio_c0_gnt", c0_gnt, 32'd1);
    chk("rm_prio_c1_gnt", c1_gnt, 32'd0);
    tick();
    c0_req = 1'b0; c1_req = 1'b0;
    settle();
    chk("rm_c0_rvalid", c0_rvalid, 32'd1);
    chk("rm_c0_instr", c0_instr, 32'hC0DE_0004);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
